ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  Multi-cycle HI/LO engine in the EX stage, directly downstream of ID. Consumes the
//  6-bit mul/div op vector ({div,divu,mult,multu,mtlo,mthi}) and rs/rt operands that ID
//  packs into id_to_ex_bus. Runs iterative multiply/divide, holds the pipeline via a stall
//  request, then emits a one-cycle HI/LO write toward MEM/WB and the ID forwarding path.
// PARAMETERS
//  XLEN      32  operand width; products/quotients are 2*XLEN / XLEN.
//  CNT_W     6   iteration counter width; must satisfy 2**CNT_W > XLEN.
// PORTS
//  clk             in   1     rising-edge clock
//  rst             in   1     asynchronous, active-high reset
//  op_valid        in   1     EX holds a valid instruction this cycle (held stable while stalled)
//  md_op           in   6     {div,divu,mult,multu,mtlo,mthi}, one-hot or zero
//  src_a           in   32    rs value (dividend / multiplicand / mthi-mtlo data)
//  src_b           in   32    rt value (divisor / multiplier)
//  cancel          in   1     flush: abort any operation in flight
//  stallreq_for_ex out  1     request pipeline stall (combinational)
//  busy            out  1     state != IDLE
//  hi_we, lo_we    out  1,1   HI/LO write strobes
//  hi_wdata        out  32    HI write data
//  lo_wdata        out  32    LO write data
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, acc/operand regs=0; all outputs 0.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE: long op = op_valid & (div|divu|mult|multu).
//   - long op & !cancel: latch |src_a|,|src_b| (signed ops) or raw (unsigned), result-sign
//     flags, counter=0; go MUL or DIV. stallreq_for_ex=1 this cycle.
//   - divisor==0 (div/divu): go straight to DONE; LO=32'hFFFF_FFFF, HI=src_a.
//   - mthi/mtlo: same cycle, combinational hi_we/lo_we=1, data=src_a; no stall, stay IDLE.
//   - multiple md_op bits: priority div>divu>mult>multu>mtlo>mthi.
//  MUL: shift-add, one multiplier bit per cycle, 32 cycles; stall held high.
//  DIV: restoring, one quotient bit per cycle, 32 cycles; stall held high.
//  After 32nd iteration -> DONE. Sign fix on entering DONE: product negated if signs differ;
//   quotient negated if signs differ; remainder takes dividend sign. Signed -2^31/-1:
//   LO=32'h8000_0000, HI=0 (natural wrap).
//  DONE: hi_we=lo_we=1 for exactly one cycle, HI=product[63:32]/remainder,
//   LO=product[31:0]/quotient; stallreq_for_ex=0 so EX advances on this edge; op_valid is
//   ignored in DONE (no restart of the same instruction); next state IDLE.
//  Latency: mult/div accepted cycle 0, stall cycles 0..32, write in cycle 33. Div-by-zero:
//   stall cycle 0, write cycle 1.
//  cancel: any state -> IDLE on next edge, no write strobe, stallreq_for_ex=0 in the
//   cancel cycle; cancel beats a start in the same cycle and suppresses mthi/mtlo strobes.
//  Async rst mid-operation: immediate IDLE, outputs 0, no partial write.
//  Outputs in DONE come from registers; only IDLE mthi/mtlo path and stallreq are comb.
// STRUCTURE
//  lib/defines.vh: state encodings, MD op bit indices (MD_DIV..MD_MTHI), MD_OP_WD=6.
//  Sub-module div_restoring_core: one restoring step (rem/quot/divisor in, next out), comb.
//  FSM, counter, multiply accumulator and sign-fix logic live in ex_muldiv_unit.
// TESTING
//  1 multu 0xFFFF_FFFF*0xFFFF_FFFF -> stall 33 cycles, cycle 33 HI=0xFFFF_FFFE, LO=0x1.
//  2 mult -3*7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; div -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
//  3 divu 100/0 -> 1 stall cycle, next cycle LO=0xFFFF_FFFF, HI=100; div 0x8000_0000/-1
//    -> LO=0x8000_0000, HI=0.
//  4 mthi 0x1234_5678 in IDLE -> same cycle hi_we=1, hi_wdata=0x1234_5678, no stall.
//  5 cancel at iteration 10 of div -> next cycle IDLE, no we ever; new mult next cycle runs.
//  6 rst asserted mid-MUL (async, between edges) -> outputs 0 immediately; op_valid held
//    through DONE -> exactly one write pulse, no second start.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and op-vector bit positions for the EX-stage HI/LO engine.
package ex_muldiv_unit_pkg;

  localparam int unsigned MD_OP_WD = 6;

  // Bit positions inside md_op = {div, divu, mult, multu, mtlo, mthi}
  localparam int unsigned MD_DIV   = 5;
  localparam int unsigned MD_DIVU  = 4;
  localparam int unsigned MD_MULT  = 3;
  localparam int unsigned MD_MULTU = 2;
  localparam int unsigned MD_MTLO  = 1;
  localparam int unsigned MD_MTHI  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_div_restoring_core.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and shift in the quotient bit.
module ex_muldiv_unit_div_restoring_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0] rem_shift;
  logic [XLEN:0] diff;

  // quot holds the unconsumed dividend bits (MSB next) and collects quotient bits at the LSB
  always_comb begin
    rem_shift = {rem, quot[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor};
    if (rem_shift >= {1'b0, divisor}) begin
      rem_next  = diff[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b1};
    end else begin
      rem_next  = rem_shift[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO multiply/divide engine: stalls the pipeline while running and
// emits a single HI/LO write once the result is ready.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [MD_OP_WD-1:0] md_op,
  input  logic [XLEN-1:0]     src_a,
  input  logic [XLEN-1:0]     src_b,
  input  logic                cancel,
  output logic                stallreq_for_ex,
  output logic                busy,
  output logic                hi_we,
  output logic                lo_we,
  output logic [XLEN-1:0]     hi_wdata,
  output logic [XLEN-1:0]     lo_wdata
);

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;      // product, or {remainder, quotient/dividend}
  logic [2*XLEN-1:0]     mcand_q, mcand_d;  // left-shifting multiplicand
  logic [XLEN-1:0]       opb_q, opb_d;      // right-shifting multiplier, or divisor
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic                  neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  logic                  sel_mthi, sel_mtlo, long_sel, is_div_op, is_signed;
  logic                  long_op, last_iter, done_we, mt_ok;
  logic [XLEN-1:0]       a_abs, b_abs, rem_next, quot_next;
  logic [2*XLEN-1:0]     mul_sum, prod_fixed;

  assign long_sel  = |md_op[MD_DIV:MD_MULTU];
  assign sel_mtlo  = !long_sel && md_op[MD_MTLO];
  assign sel_mthi  = !long_sel && !md_op[MD_MTLO] && md_op[MD_MTHI];
  assign is_div_op = md_op[MD_DIV] || md_op[MD_DIVU];
  // Signed only when the winning op is div or mult
  assign is_signed = md_op[MD_DIV] || (!md_op[MD_DIVU] && md_op[MD_MULT]);
  assign long_op   = op_valid && long_sel;
  assign a_abs     = (is_signed && src_a[XLEN-1]) ? (~src_a + 1'b1) : src_a;
  assign b_abs     = (is_signed && src_b[XLEN-1]) ? (~src_b + 1'b1) : src_b;
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
  assign mul_sum   = acc_q + (opb_q[0] ? mcand_q : '0);
  assign prod_fixed = neg_res_q ? (~mul_sum + 1'b1) : mul_sum;

  ex_muldiv_unit_div_restoring_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .rem      (acc_q[2*XLEN-1:XLEN]),
    .quot     (acc_q[XLEN-1:0]),
    .divisor  (opb_q),
    .rem_next (rem_next),
    .quot_next(quot_next)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Next-state: start, iterate, sign-fix into HI/LO on the final step
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    if (cancel) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (long_op) begin
            neg_res_d = is_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
            neg_rem_d = is_signed && src_a[XLEN-1];
            cnt_d     = '0;
            opb_d     = b_abs;
            if (is_div_op) begin
              mcand_d = '0;
              acc_d   = {{XLEN{1'b0}}, a_abs};
              if (src_b == '0) begin
                hi_d    = src_a;
                lo_d    = '1;
                state_d = StDone;
              end else begin
                state_d = StDiv;
              end
            end else begin
              acc_d   = '0;
              mcand_d = {{XLEN{1'b0}}, a_abs};
              state_d = StMul;
            end
          end
        end
        StMul: begin
          acc_d   = mul_sum;
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi_d    = prod_fixed[2*XLEN-1:XLEN];
            lo_d    = prod_fixed[XLEN-1:0];
            state_d = StDone;
          end
        end
        StDiv: begin
          acc_d = {rem_next, quot_next};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            lo_d    = neg_res_q ? (~quot_next + 1'b1) : quot_next;
            hi_d    = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs: registered result in DONE, same-cycle mthi/mtlo bypass in IDLE
  always_comb begin
    done_we         = !rst && !cancel && (state_q == StDone);
    mt_ok           = !rst && !cancel && (state_q == StIdle) && op_valid;
    stallreq_for_ex = !rst && !cancel &&
                      (((state_q == StIdle) && long_op) ||
                       (state_q == StMul) || (state_q == StDiv));
    busy            = (state_q != StIdle);
    hi_we           = done_we || (mt_ok && sel_mthi);
    lo_we           = done_we || (mt_ok && sel_mtlo);
    hi_wdata        = '0;
    lo_wdata        = '0;
    if (done_we) begin
      hi_wdata = hi_q;
      lo_wdata = lo_q;
    end else if (mt_ok && sel_mthi) begin
      hi_wdata = src_a;
    end else if (mt_ok && sel_mtlo) begin
      lo_wdata = src_a;
    end
  end

endmodule
